// File: rtl/lut_truth_table_reader.sv
// Truth-table readback engine for one LUT neuron: sweeps every input code, packs the
// responses LSB-first into WORD_W-bit words and streams them out over valid/ready.
module lut_truth_table_reader #(
  parameter int unsigned IN_BITS  = 8,
  parameter int unsigned OUT_BITS = 1,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned LUT_LAT  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [IN_BITS-1:0]  lut_in,
  input  logic [OUT_BITS-1:0] lut_out,
  output logic [WORD_W-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                busy,
  output logic                done
);

  localparam int unsigned ENTRIES = 1 << IN_BITS;
  localparam int unsigned EPW     = WORD_W / OUT_BITS;
  localparam int unsigned NWORDS  = (ENTRIES * OUT_BITS + WORD_W - 1) / WORD_W;
  localparam int unsigned SlotW   = (EPW > 1) ? $clog2(EPW) : 1;
  localparam int unsigned WordW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned LatW    = (LUT_LAT > 0) ? $clog2(LUT_LAT + 1) : 1;

  localparam logic [IN_BITS:0] LastCode = (IN_BITS + 1)'(ENTRIES - 1);
  localparam logic [SlotW-1:0] LastSlot = SlotW'(EPW - 1);
  localparam logic [WordW-1:0] LastWord = WordW'(NWORDS - 1);
  localparam logic [LatW-1:0]  LastLat  = LatW'(LUT_LAT);

  typedef enum logic [1:0] {StIdle, StSweep, StHold, StDone} state_e;

  state_e              state_q, state_d;
  logic [IN_BITS:0]    code_q, code_d;
  logic [IN_BITS-1:0]  lut_in_q, lut_in_d;
  logic [SlotW-1:0]    slot_q, slot_d;
  logic [WordW-1:0]    word_q, word_d;
  logic [LatW-1:0]     lat_q, lat_d;
  logic [WORD_W-1:0]   buf_q, buf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      code_q   <= '0;
      lut_in_q <= '0;
      slot_q   <= '0;
      word_q   <= '0;
      lat_q    <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      lut_in_q <= lut_in_d;
      slot_q   <= slot_d;
      word_q   <= word_d;
      lat_q    <= lat_d;
      buf_q    <= buf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    lut_in_d = lut_in_q;
    slot_d   = slot_q;
    word_d   = word_q;
    lat_d    = lat_q;
    buf_d    = buf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StSweep;
          code_d   = '0;
          lut_in_d = '0;
          slot_d   = '0;
          word_d   = '0;
          lat_d    = '0;
          buf_d    = '0;
        end
      end
      StSweep: begin
        if (lat_q == LastLat) begin
          // Sample on the last cycle the code has been held.
          lat_d = '0;
          buf_d[int'(slot_q) * OUT_BITS +: OUT_BITS] = lut_out;
          code_d = code_q + (IN_BITS + 1)'(1);
          if (slot_q == LastSlot || code_q == LastCode) begin
            state_d = StHold;
          end else begin
            slot_d   = slot_q + SlotW'(1);
            lut_in_d = code_d[IN_BITS-1:0];
          end
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StHold: begin
        if (m_ready) begin
          buf_d  = '0;
          slot_d = '0;
          if (word_q == LastWord) begin
            state_d = StDone;
          end else begin
            state_d  = StSweep;
            word_d   = word_q + WordW'(1);
            lut_in_d = code_q[IN_BITS-1:0];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        code_d  = '0;
        word_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  assign lut_in  = lut_in_q;
  assign m_data  = buf_q;
  assign m_valid = (state_q == StHold);
  assign m_last  = (state_q == StHold) && (word_q == LastWord);
  assign busy    = (state_q == StSweep) || (state_q == StHold);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_lut_truth_table_reader.sv
// Directed bench: three reader instances (default, LUT_LAT=2 registered neuron, OUT_BITS=2)
// each driven by a small neuron model; expected words are hand-computed constants.
module tb_lut_truth_table_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int mode   = 0;

  // Instance 0: defaults, combinational neuron selected by mode
  logic        start0 = 1'b0, ready0 = 1'b1;
  logic [7:0]  lut_in0;
  logic        lut_out0;
  logic [31:0] m_data0;
  logic        m_valid0, m_last0, busy0, done0;
  assign lut_out0 = (mode == 1) ? (lut_in0 == 8'hFF) : lut_in0[0];

  lut_truth_table_reader dut0 (
    .clk(clk), .rst(rst), .start(start0), .lut_in(lut_in0), .lut_out(lut_out0),
    .m_data(m_data0), .m_valid(m_valid0), .m_ready(ready0), .m_last(m_last0),
    .busy(busy0), .done(done0)
  );

  // Instance 1: two-cycle registered neuron computing lut_in[1]
  logic        start1 = 1'b0, ready1 = 1'b1;
  logic [7:0]  lut_in1;
  logic        pipe_a = 1'b0, pipe_b = 1'b0;
  logic [31:0] m_data1;
  logic        m_valid1, m_last1, busy1, done1;
  always @(posedge clk) begin
    pipe_a <= lut_in1[1];
    pipe_b <= pipe_a;
  end

  lut_truth_table_reader #(.LUT_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .lut_in(lut_in1), .lut_out(pipe_b),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(ready1), .m_last(m_last1),
    .busy(busy1), .done(done1)
  );

  // Instance 2: two-bit neuron output lut_in[1:0]
  logic        start2 = 1'b0, ready2 = 1'b1;
  logic [7:0]  lut_in2;
  logic [1:0]  lut_out2;
  logic [31:0] m_data2;
  logic        m_valid2, m_last2, busy2, done2;
  assign lut_out2 = lut_in2[1:0];

  lut_truth_table_reader #(.OUT_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .lut_in(lut_in2), .lut_out(lut_out2),
    .m_data(m_data2), .m_valid(m_valid2), .m_ready(ready2), .m_last(m_last2),
    .busy(busy2), .done(done2)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_valid0, m_last0, busy0, done0} !== 4'b0)
      $display("FAIL reset_ctrl: got %b want 0000", {m_valid0, m_last0, busy0, done0});
    else passes++;
    checks++;
    if (m_data0 !== 32'h0) $display("FAIL reset_data: got %h want 00000000", m_data0);
    else passes++;
    checks++;
    if (lut_in0 !== 8'h00) $display("FAIL reset_lut_in: got %h want 00", lut_in0);
    else passes++;
    checks++;
    if ({busy1, busy2, m_valid1, m_valid2} !== 4'b0)
      $display("FAIL reset_others: got %b want 0000", {busy1, busy2, m_valid1, m_valid2});
    else passes++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Full run on instance 0; m selects the neuron, poke re-asserts start while busy.
  task automatic test_sweep(input int m, input bit poke);
    int widx;
    int prev;
    bit fin;
    logic [31:0] exp;
    mode   = m;
    ready0 = 1'b1;
    start0 = 1'b1;
    widx   = 0;
    prev   = 0;
    fin    = 1'b0;
    for (int c = 1; c <= 400 && !fin; c++) begin
      @(posedge clk);
      #1;
      start0 = poke && (c == 10);
      if (m_valid0) begin
        exp = (m == 1) ? ((widx == 7) ? 32'h8000_0000 : 32'h0) : 32'hAAAA_AAAA;
        checks++;
        if (m_data0 !== exp) $display("FAIL sweep%0d_data[%0d]: got %h want %h", m, widx, m_data0, exp);
        else passes++;
        checks++;
        if (m_last0 !== (widx == 7)) $display("FAIL sweep%0d_last[%0d]: got %b want %b", m, widx, m_last0, widx == 7);
        else passes++;
        checks++;
        if ((c - prev) !== 33) $display("FAIL sweep%0d_gap[%0d]: got %0d want 33", m, widx, c - prev);
        else passes++;
        prev = c;
        fin  = m_last0;
        widx++;
      end
    end
    checks++;
    if (widx !== 8) $display("FAIL sweep%0d_words: got %0d want 8", m, widx);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if ({done0, busy0} !== 2'b10) $display("FAIL sweep%0d_done: got %b want 10", m, {done0, busy0});
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (done0 !== 1'b0) $display("FAIL sweep%0d_done_pulse: got %b want 0", m, done0);
    else passes++;
  endtask

  task automatic test_backpressure();
    int nvalid;
    bit found;
    bit seen_done;
    mode   = 0;
    ready0 = 1'b1;
    start0 = 1'b1;
    nvalid = 0;
    found  = 1'b0;
    for (int c = 1; c <= 200 && !found; c++) begin
      @(posedge clk);
      #1;
      start0 = 1'b0;
      if (m_valid0) begin
        if (nvalid == 3) found = 1'b1;
        else nvalid++;
      end
    end
    checks++;
    if (!found) $display("FAIL bp_reach_word3: got %0d words want 4", nvalid);
    else passes++;
    ready0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({m_valid0, m_data0, lut_in0} !== {1'b1, 32'hAAAA_AAAA, 8'h7F})
        $display("FAIL bp_hold[%0d]: got %b/%h/%h want 1/aaaaaaaa/7f", i, m_valid0, m_data0, lut_in0);
      else passes++;
    end
    ready0 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({m_valid0, busy0, lut_in0} !== {1'b0, 1'b1, 8'h80})
      $display("FAIL bp_resume: got %b/%b/%h want 0/1/80", m_valid0, busy0, lut_in0);
    else passes++;
    seen_done = 1'b0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      @(posedge clk);
      #1;
      seen_done = done0;
    end
    checks++;
    if (!seen_done) $display("FAIL bp_done: got 0 want 1");
    else passes++;
  endtask

  task automatic test_latency();
    int widx;
    int prev;
    bit fin;
    start1 = 1'b1;
    widx   = 0;
    prev   = 0;
    fin    = 1'b0;
    for (int c = 1; c <= 1000 && !fin; c++) begin
      @(posedge clk);
      #1;
      start1 = 1'b0;
      if (m_valid1) begin
        checks++;
        if (m_data1 !== 32'hCCCC_CCCC) $display("FAIL lat_data[%0d]: got %h want cccccccc", widx, m_data1);
        else passes++;
        checks++;
        if ((c - prev) !== 97) $display("FAIL lat_gap[%0d]: got %0d want 97", widx, c - prev);
        else passes++;
        prev = c;
        fin  = m_last1;
        widx++;
      end
    end
    checks++;
    if (widx !== 8) $display("FAIL lat_words: got %0d want 8", widx);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (done1 !== 1'b1) $display("FAIL lat_done: got %b want 1", done1);
    else passes++;
  endtask

  task automatic test_wide();
    int widx;
    int prev;
    bit fin;
    start2 = 1'b1;
    widx   = 0;
    prev   = 0;
    fin    = 1'b0;
    for (int c = 1; c <= 400 && !fin; c++) begin
      @(posedge clk);
      #1;
      start2 = 1'b0;
      if (m_valid2) begin
        checks++;
        if (m_data2 !== 32'hE4E4_E4E4) $display("FAIL wide_data[%0d]: got %h want e4e4e4e4", widx, m_data2);
        else passes++;
        checks++;
        if (m_last2 !== (widx == 15)) $display("FAIL wide_last[%0d]: got %b want %b", widx, m_last2, widx == 15);
        else passes++;
        checks++;
        if ((c - prev) !== 17) $display("FAIL wide_gap[%0d]: got %0d want 17", widx, c - prev);
        else passes++;
        prev = c;
        fin  = m_last2;
        widx++;
      end
    end
    checks++;
    if (widx !== 16) $display("FAIL wide_words: got %0d want 16", widx);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (done2 !== 1'b1) $display("FAIL wide_done: got %b want 1", done2);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int nvalid;
    mode   = 0;
    ready0 = 1'b1;
    start0 = 1'b1;
    nvalid = 0;
    for (int c = 1; c <= 200 && nvalid < 4; c++) begin
      @(posedge clk);
      #1;
      start0 = 1'b0;
      if (m_valid0) nvalid++;
    end
    checks++;
    if (nvalid !== 4) $display("FAIL rstmid_words: got %0d want 4", nvalid);
    else passes++;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy0);
    else passes++;
    // Reset and start together: reset must win.
    rst    = 1'b1;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    start0 = 1'b0;
    checks++;
    if ({busy0, m_valid0, done0, lut_in0, m_data0} !== 43'h0)
      $display("FAIL rstmid_clear: got %b/%b/%b/%h/%h want 0/0/0/00/00000000",
               busy0, m_valid0, done0, lut_in0, m_data0);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0) $display("FAIL rstmid_start_ignored: got %b want 0", busy0);
    else passes++;
    test_sweep(0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_sweep(0, 1'b0);
    test_sweep(1, 1'b0);
    test_backpressure();
    test_latency();
    test_wide();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lut_truth_table_reader.md
Name: lut_truth_table_reader

Overview:
Readback engine for a single synthesized LUT neuron, the counterpart to the neuron's lookup interface. The neuron maps an IN_BITS fan-in code to an OUT_BITS activation. This block drives every code 0..2^IN_BITS-1 into the neuron's input and captures each response. It packs the responses into WORD_W-bit words and streams them out over a valid/ready interface. It is used for hardware-vs-model truth-table checks and for on-chip readback of generated neuron tables.

Parameters:
IN_BITS, 8, neuron fan-in width; ENTRIES = 2^IN_BITS
OUT_BITS, 1, neuron output width; WORD_W must be a multiple of OUT_BITS
WORD_W, 32, output word width; EPW = WORD_W/OUT_BITS entries per word
LUT_LAT, 0, cycles from lut_in change to valid lut_out (0 = combinational neuron)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a readback; sampled only in IDLE
lut_in  output  IN_BITS  code driven into the neuron under test
lut_out  input  OUT_BITS  neuron response
m_data  output  WORD_W  packed truth-table word
m_valid  output  1  m_data valid
m_ready  input  1  downstream accept
m_last  output  1  high with m_valid on the final word
busy  output  1  high in SWEEP or HOLD
done  output  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset values: all outputs 0. State IDLE, code counter 0, word buffer 0.
- Word count: NWORDS = ceil(ENTRIES*OUT_BITS/WORD_W).
- Packing: entry k occupies stream bits [k*OUT_BITS +: OUT_BITS], LSB-first. Word j holds entries j*EPW .. j*EPW+EPW-1.
- Padding: unfilled upper bits of the last word are 0.
- FSM state IDLE:
  - start=1 -> SWEEP, code=0.
  - start while not in IDLE is ignored.
- FSM state SWEEP:
  - lut_in = code, held for LUT_LAT+1 cycles.
  - On the last of those cycles, lut_out is written into buffer slot (code mod EPW) and code increments.
  - When the slot written is EPW-1, or code was ENTRIES-1 -> HOLD.
- FSM state HOLD:
  - m_valid=1, m_data = buffer, m_last = (word index == NWORDS-1).
  - lut_in holds its last value.
- Handshake:
  - While m_valid && !m_ready, m_data, m_last and lut_in are stable.
  - On m_valid && m_ready with m_last=0 -> buffer cleared, SWEEP resumes at the next code.
  - On m_valid && m_ready with m_last=1 -> DONE.
- FSM state DONE: done=1 for exactly one cycle, then IDLE. The code counter wraps to 0.
- Latency (defaults): start sampled at cycle 0.
  - SWEEP cycles 1..32 cover codes 0..31; first m_valid at cycle 33.
  - With m_ready tied high, each subsequent word takes 32 SWEEP cycles + 1 HOLD cycle.
  - done asserts 1 cycle after the m_last handshake.
- Sample timing: with LUT_LAT=N, the sample for a code is taken N cycles after lut_in first shows that code. No overlap between codes; the sweep is not pipelined.
- Reset mid-operation: rst in any state returns to IDLE with reset values next cycle. The partial word is discarded and no done is issued. A new start re-reads from code 0.
- Simultaneous start and rst: rst wins.
- Counters are sized to ENTRIES without overflow. The code counter is IN_BITS+1 bits internally; the terminal condition is code==ENTRIES-1.

Test Plan:
- Neuron lut_out = lut_in[0], defaults, m_ready=1 -> 8 words, each 0xAAAAAAAA; m_last on word 7; done at the cycle after that handshake; first m_valid 33 cycles after start.
- Neuron lut_out = (lut_in==8'hFF) -> words 0..6 = 0x00000000, word 7 = 0x80000000.
- Backpressure:
  - Stimulus: m_ready low for 10 cycles while word 3 is presented (lut_out = lut_in[0]).
  - Response: m_data stays 0xAAAAAAAA and lut_in stays 8'h7F throughout.
  - Sweep resumes at code 8'h80 the cycle after acceptance.
- LUT_LAT=2 with a registered neuron lut_out = lut_in[1] -> every word 0xCCCCCCCC; each word's sweep takes 96 cycles.
- rst asserted mid-sweep of word 4 -> next cycle busy=0, m_valid=0, lut_in=0. Start asserted while busy during the next run is ignored. The new run streams all 8 words starting at word 0 with correct data.
- OUT_BITS=2, WORD_W=32, neuron lut_out = lut_in[1:0] -> 16 words, each 0xE4E4E4E4; m_last on word 15.
